// File: rtl/audio_meter_pkg.sv
// Shared types and helpers for the stereo level meter: peak-hold FSM states,
// default sizing constants and the saturating absolute-value function.
package audio_meter_pkg;

   localparam int DATA_WIDTH_DEF  = 24;
   localparam int OUT_WIDTH_DEF   = 13;
   localparam int DECAY_SHIFT_DEF = 3;
   localparam int HOLD_CYCLES_DEF = 25000000;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      HOLD    = 2'd1,
      RELEASE = 2'd2
   } peak_state_t;

   // The most negative sample has no positive twin, so it clamps to max positive.
   function automatic logic [DATA_WIDTH_DEF-2:0] abs_sat(
      input logic [DATA_WIDTH_DEF-1:0] x
   );
      logic [DATA_WIDTH_DEF-1:0] neg;
      neg = ~x + {{(DATA_WIDTH_DEF-1){1'b0}}, 1'b1};
      if (!x[DATA_WIDTH_DEF-1]) begin
         return x[DATA_WIDTH_DEF-2:0];
      end
      if (neg[DATA_WIDTH_DEF-1]) begin
         return '1;
      end
      return neg[DATA_WIDTH_DEF-2:0];
   endfunction

endpackage

// File: rtl/meter_peak_hold.sv
// Peak-hold tracker: latches the largest magnitude, holds it for a fixed
// time, then follows the decaying envelope back down to idle.
module meter_peak_hold
   import audio_meter_pkg::*;
#(
   parameter int OUT_WIDTH   = OUT_WIDTH_DEF,
   parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic                 update,
   input  logic [OUT_WIDTH-1:0] mag,
   input  logic [OUT_WIDTH-1:0] level,
   output logic [OUT_WIDTH-1:0] peak
);

   localparam int CNT_WIDTH = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_WIDTH-1:0] CNT_RELOAD = CNT_WIDTH'(HOLD_CYCLES - 1);

   peak_state_t          state_reg, state_next;
   logic [OUT_WIDTH-1:0] peak_reg, peak_next;
   logic [CNT_WIDTH-1:0] hold_cnt_reg, hold_cnt_next;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg    <= IDLE;
         peak_reg     <= '0;
         hold_cnt_reg <= '0;
      end else begin
         state_reg    <= state_next;
         peak_reg     <= peak_next;
         hold_cnt_reg <= hold_cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      peak_next     = peak_reg;
      hold_cnt_next = hold_cnt_reg;
      case (state_reg)
         IDLE: begin
            peak_next = '0;
            if (update && (mag != '0)) begin
               peak_next     = mag;
               hold_cnt_next = CNT_RELOAD;
               state_next    = HOLD;
            end
         end
         HOLD: begin
            if (hold_cnt_reg != '0) begin
               hold_cnt_next = hold_cnt_reg - CNT_WIDTH'(1);
            end
            // A larger peak arriving on the expiry cycle still restarts the hold.
            if (update && (mag > peak_reg)) begin
               peak_next     = mag;
               hold_cnt_next = CNT_RELOAD;
            end else if (hold_cnt_reg == '0) begin
               state_next = RELEASE;
            end
         end
         RELEASE: begin
            if (update) begin
               if (mag > peak_reg) begin
                  peak_next     = mag;
                  hold_cnt_next = CNT_RELOAD;
                  state_next    = HOLD;
               end else begin
                  peak_next = level;
                  if (level == '0) begin
                     state_next = IDLE;
                  end
               end
            end
         end
         default: begin
            state_next = IDLE;
            peak_next  = '0;
         end
      endcase
   end

   assign peak = peak_reg;

endmodule

// File: rtl/level_meter.sv
// Stereo level meter: detects frames from the codec LR clock and produces an
// envelope level, held peak and sticky clip flag for the display path.
module level_meter
   import audio_meter_pkg::*;
#(
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int OUT_WIDTH   = OUT_WIDTH_DEF,
   parameter int DECAY_SHIFT = DECAY_SHIFT_DEF,
   parameter int HOLD_CYCLES = HOLD_CYCLES_DEF
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  lrclk,
   input  logic [DATA_WIDTH-1:0] left_in,
   input  logic [DATA_WIDTH-1:0] right_in,
   output logic [OUT_WIDTH-1:0]  level,
   output logic [OUT_WIDTH-1:0]  peak,
   output logic                  clip,
   output logic                  level_valid
);

   localparam int CNT_WIDTH = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
   localparam logic [CNT_WIDTH-1:0]  CNT_RELOAD = CNT_WIDTH'(HOLD_CYCLES - 1);
   localparam logic [DATA_WIDTH-1:0] MAX_POS    = {1'b0, {(DATA_WIDTH-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] MIN_NEG    = {1'b1, {(DATA_WIDTH-1){1'b0}}};

   logic                  s1_reg, s2_reg, s3_reg;
   logic                  frame_stb;
   logic                  v1_reg, v2_reg, v3_reg;
   logic [DATA_WIDTH-1:0] samp_in [2];
   logic [DATA_WIDTH-2:0] abs_ch  [2];
   logic [1:0]            hit_ch;
   logic                  hit3_reg;
   logic [OUT_WIDTH-1:0]  mag_reg;
   logic [OUT_WIDTH-1:0]  level_reg, level_next, decay_step;
   logic                  clip_reg;
   logic [CNT_WIDTH-1:0]  clip_cnt_reg;
   logic                  valid_reg;
   logic [OUT_WIDTH-1:0]  peak_w;

   assign frame_stb  = s2_reg & ~s3_reg;
   assign samp_in[0] = left_in;
   assign samp_in[1] = right_in;

   // lrclk is asynchronous; two flops for metastability, a third for the edge.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         s1_reg   <= 1'b0;
         s2_reg   <= 1'b0;
         s3_reg   <= 1'b0;
         v1_reg   <= 1'b0;
         v2_reg   <= 1'b0;
         v3_reg   <= 1'b0;
         hit3_reg <= 1'b0;
         mag_reg  <= '0;
      end else begin
         s1_reg <= lrclk;
         s2_reg <= s1_reg;
         s3_reg <= s2_reg;
         v1_reg <= frame_stb;
         v2_reg <= v1_reg;
         v3_reg <= v2_reg;
         if (v2_reg) begin
            hit3_reg <= |hit_ch;
            mag_reg  <= (abs_ch[0] >= abs_ch[1]) ? abs_ch[0][DATA_WIDTH-2 -: OUT_WIDTH]
                                                 : abs_ch[1][DATA_WIDTH-2 -: OUT_WIDTH];
         end
      end
   end

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_ch
         logic [DATA_WIDTH-1:0] samp_reg;
         logic [DATA_WIDTH-2:0] abs_reg;
         logic                  hit_reg;

         always_ff @(posedge clk) begin
            if (!reset_n) begin
               samp_reg <= '0;
               abs_reg  <= '0;
               hit_reg  <= 1'b0;
            end else begin
               if (frame_stb) begin
                  samp_reg <= samp_in[gi];
               end
               if (v1_reg) begin
                  abs_reg <= abs_sat(samp_reg);
                  hit_reg <= (samp_reg == MAX_POS) || (samp_reg == MIN_NEG);
               end
            end
         end

         assign abs_ch[gi] = abs_reg;
         assign hit_ch[gi] = hit_reg;
      end
   endgenerate

   // Instant attack; release removes at least one LSB so small levels reach zero.
   always_comb begin
      decay_step = level_reg >> DECAY_SHIFT;
      if (decay_step == '0) begin
         decay_step = {{(OUT_WIDTH-1){1'b0}}, 1'b1};
      end
      level_next = level_reg;
      if (v3_reg) begin
         if (mag_reg >= level_reg) begin
            level_next = mag_reg;
         end else begin
            level_next = level_reg - decay_step;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         level_reg    <= '0;
         valid_reg    <= 1'b0;
         clip_reg     <= 1'b0;
         clip_cnt_reg <= '0;
      end else begin
         level_reg <= level_next;
         valid_reg <= v3_reg;
         if (v3_reg && hit3_reg) begin
            clip_reg     <= 1'b1;
            clip_cnt_reg <= CNT_RELOAD;
         end else if (clip_reg) begin
            if (clip_cnt_reg == '0) begin
               clip_reg <= 1'b0;
            end else begin
               clip_cnt_reg <= clip_cnt_reg - CNT_WIDTH'(1);
            end
         end
      end
   end

   meter_peak_hold #(
      .OUT_WIDTH   (OUT_WIDTH),
      .HOLD_CYCLES (HOLD_CYCLES)
   ) u_peak (
      .clk     (clk),
      .reset_n (reset_n),
      .update  (v3_reg),
      .mag     (mag_reg),
      .level   (level_next),
      .peak    (peak_w)
   );

   assign level       = level_reg;
   assign peak        = peak_w;
   assign clip        = clip_reg;
   assign level_valid = valid_reg;

endmodule

// File: doc/level_meter.md
Name: level_meter

Overview:
- Downstream consumer of the delayed stereo samples; replaces the raw per-sample latch that feeds dado_bcd and the 7-segment displays.
- Produces three display-ready results in the system clock domain:
  - an envelope level with instant attack and exponential release,
  - a peak-hold value with timed hold,
  - a sticky clip flag.
- Frames are detected from the codec's LR clock, synchronised into clk.

Parameters:
- DATA_WIDTH, 24: signed sample width from in_i2s/delay.
- OUT_WIDTH, 13: magnitude width presented to the display path.
- DECAY_SHIFT, 3: release step is level>>DECAY_SHIFT per frame.
- HOLD_CYCLES, 25000000: peak and clip hold time in clk cycles (0.5 s at 50 MHz).

Ports:
- clk, input, 1: system clock, 50 MHz board clock.
- reset_n, input, 1: synchronous active-low reset.
- lrclk, input, 1: codec ADCLRC, asynchronous to clk.
- left_in, input, DATA_WIDTH: signed left sample. Stable for a full frame around the lrclk rising edge.
- right_in, input, DATA_WIDTH: signed right sample. Same timing as left_in.
- level, output, OUT_WIDTH: envelope magnitude.
- peak, output, OUT_WIDTH: held peak magnitude.
- clip, output, 1: high while a full-scale sample was seen within the last HOLD_CYCLES.
- level_valid, output, 1: one-cycle pulse when level/peak update.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-low (reset_n).
- Reset (reset_n low at a clk edge):
  - level, peak, clip, level_valid = 0.
  - Sync flops, pipeline valids and counters cleared.
  - Peak FSM goes to IDLE.
  - Reset mid-frame discards any in-flight sample; no level_valid is produced for it.
- Synchroniser:
  - lrclk passes through 2 flops, then a 3rd flop for edge detect.
  - frame_stb = s2 & ~s3, i.e. the rising edge of the synchronised lrclk.
- Pipeline, relative to the frame_stb cycle T:
  - T+1: left_in/right_in registered.
  - T+2: saturating absolute value per channel (abs of the most negative value = 2^(DATA_WIDTH-1)-1). clip_hit = either raw sample equals max positive or min negative.
  - T+3: mag = max(absL, absR) bits [DATA_WIDTH-2 -: OUT_WIDTH].
  - T+4: level/peak/clip update; level_valid high for exactly this cycle.
- A frame_stb arriving while the pipeline is busy is legal. Frames are ≥ 64 clk apart in practice, but the pipeline is fully pipelined, so back-to-back strobes each produce their own level_valid.
- Level update:
  - If mag >= level: level <= mag.
  - Else: level <= level - max(level>>DECAY_SHIFT, 1).
  - level never underflows below 0.
- Peak FSM, evaluated on each update cycle unless noted:
  - IDLE: peak = 0. On mag > 0: peak <= mag, hold_cnt <= HOLD_CYCLES-1, go to HOLD.
  - HOLD:
    - hold_cnt decrements every clk.
    - On an update with mag > peak: peak <= mag and hold_cnt reloads.
    - When hold_cnt == 0: go to RELEASE.
  - RELEASE:
    - On each update: peak <= new level.
    - If mag > peak: reload and go to HOLD.
    - If new level == 0: go to IDLE.
  - Simultaneous hold_cnt == 0 and update with mag > peak: the reload wins, and the FSM stays in HOLD.
- Clip:
  - clip_hit at the update stage sets clip = 1 and reloads clip_cnt to HOLD_CYCLES-1.
  - clip_cnt decrements every clk; clip clears on the cycle clip_cnt reaches 0 with no new clip_hit.
- Widths: all comparisons unsigned on OUT_WIDTH; counters sized $clog2(HOLD_CYCLES).

Decomposition:
- Shared package audio_meter_pkg holds:
  - peak FSM state enum (IDLE, HOLD, RELEASE),
  - function abs_sat(signed DATA_WIDTH) returning an unsigned DATA_WIDTH-1 value,
  - the default constants above.
- One sub-module, meter_peak_hold: the peak FSM, hold counter and reload logic. It takes mag, level and an update strobe.

Test Plan (DATA_WIDTH=24, OUT_WIDTH=13, DECAY_SHIFT=3, HOLD_CYCLES=16):
1. Reset while an lrclk edge is in flight: assert reset_n low for 1 cycle at T+2 -> no level_valid; level = peak = clip = 0; FSM in IDLE.
2. Attack: left=0x400000, right=0 on an lrclk rise -> level_valid exactly 4 cycles after frame_stb; level = peak = 4096; clip = 0.
3. Release: then frames of 0 -> level 3584, 3136, 2744 on successive updates; peak stays 4096 for 16 clk, then tracks level.
4. Small-level floor: level 5 followed by a zero frame -> level 4 (min step 1). Continue -> reaches 0; peak FSM returns to IDLE.
5. Clip / saturation: right=0x800000 -> abs saturates, level = peak = 8191; clip = 1 for 16 clk after the update, then 0. A second hit at cycle 10 extends clip to cycle 26.
6. Simultaneous events: update with mag 5000 > peak 4096 on the same cycle hold_cnt hits 0 -> peak = 5000; FSM stays in HOLD; hold_cnt reloads to 15.
